// File: rtl/system_ctrl_fsm_pkg.sv
// Shared definitions for the command sequencer: frame command codes, RF address
// source selects and the sequencer state encoding.
package system_ctrl_fsm_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [1:0] RF_ADD_OP_0    = 2'd0;
  localparam logic [1:0] RF_ADD_OP_1    = 2'd1;
  localparam logic [1:0] RF_ADD_RX_DATA = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_ADDR    = 4'd1,
    ST_WR_DATA    = 4'd2,
    ST_WR_COMMIT  = 4'd3,
    ST_RD_ADDR    = 4'd4,
    ST_RD_ISSUE   = 4'd5,
    ST_RD_WAIT    = 4'd6,
    ST_OPA        = 4'd7,
    ST_OPA_COMMIT = 4'd8,
    ST_OPB        = 4'd9,
    ST_OPB_COMMIT = 4'd10,
    ST_FUNC       = 4'd11,
    ST_ALU_RUN    = 4'd12,
    ST_ALU_WAIT   = 4'd13,
    ST_TX_LOAD    = 4'd14,
    ST_TX_SEND    = 4'd15
  } state_t;

  // States that wait on an RX byte or a datapath status and can therefore time out.
  function automatic logic is_wait_state(input state_t s);
    case (s)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OPA, ST_OPB, ST_FUNC,
      ST_RD_WAIT, ST_ALU_WAIT: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/system_ctrl_fsm.sv
// Command sequencer: decodes UART RX frames into datapath control strobes and
// hands the result byte to UART TX.
module system_ctrl_fsm
  import system_ctrl_fsm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_rx_data,
  input  logic             i_rx_data_valid,
  input  logic             i_reg_file_valid,
  input  logic             i_alu_valid,
  input  logic             i_tx_ready,
  output logic             o_alu_en,
  output logic             o_ld_alu_func,
  output logic             o_alu_clk_en,
  output logic             o_en_r,
  output logic             o_en_w,
  output logic             o_ld_rf_data,
  output logic             o_rf_data_source,
  output logic             o_ld_rf_add,
  output logic [1:0]       o_rf_add_source,
  output logic             o_output_source,
  output logic             o_tx_valid,
  output logic             o_busy,
  output logic             o_frame_err
);

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            tx_src, tx_src_next;
  logic            waiting, timed_out;

  assign waiting   = is_wait_state(state);
  assign timed_out = waiting && (to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
      tx_src <= 1'b0;
    end else begin
      state  <= state_next;
      tx_src <= tx_src_next;
      // A state change (including every accepted RX byte) restarts the idle window.
      if (waiting && (state_next == state))
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;
    end
  end

  // Handshake to UART TX: o_tx_valid rises in TX_SEND and stays high with stable
  // data until i_tx_ready; the byte is transferred on the cycle both are high.
  always_comb begin
    state_next  = state;
    tx_src_next = tx_src;
    case (state)
      ST_IDLE: begin
        if (i_rx_data_valid) begin
          if      (i_rx_data == WIDTH'(CMD_RF_WR))   state_next = ST_WR_ADDR;
          else if (i_rx_data == WIDTH'(CMD_RF_RD))   state_next = ST_RD_ADDR;
          else if (i_rx_data == WIDTH'(CMD_ALU_OP))  state_next = ST_OPA;
          else if (i_rx_data == WIDTH'(CMD_ALU_NOP)) state_next = ST_FUNC;
        end
      end
      ST_WR_ADDR: begin
        if (i_rx_data_valid) state_next = ST_WR_DATA;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_WR_DATA: begin
        if (i_rx_data_valid) state_next = ST_WR_COMMIT;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_WR_COMMIT: state_next = ST_IDLE;
      ST_RD_ADDR: begin
        if (i_rx_data_valid) state_next = ST_RD_ISSUE;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_RD_ISSUE: state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_reg_file_valid) begin
          state_next  = ST_TX_LOAD;
          tx_src_next = 1'b1;
        end else if (timed_out) begin
          state_next = ST_IDLE;
        end
      end
      ST_OPA: begin
        if (i_rx_data_valid) state_next = ST_OPA_COMMIT;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_OPA_COMMIT: state_next = ST_OPB;
      ST_OPB: begin
        if (i_rx_data_valid) state_next = ST_OPB_COMMIT;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_OPB_COMMIT: state_next = ST_FUNC;
      ST_FUNC: begin
        if (i_rx_data_valid) state_next = ST_ALU_RUN;
        else if (timed_out)  state_next = ST_IDLE;
      end
      ST_ALU_RUN: state_next = ST_ALU_WAIT;
      ST_ALU_WAIT: begin
        if (i_alu_valid) begin
          state_next  = ST_TX_LOAD;
          tx_src_next = 1'b0;
        end else if (timed_out) begin
          state_next = ST_IDLE;
        end
      end
      ST_TX_LOAD: state_next = ST_TX_SEND;
      ST_TX_SEND: begin
        if (i_tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore decode of the control strobes.
  always_comb begin
    o_alu_en         = 1'b0;
    o_ld_alu_func    = 1'b0;
    o_alu_clk_en     = 1'b0;
    o_en_r           = 1'b0;
    o_en_w           = 1'b0;
    o_ld_rf_data     = 1'b0;
    o_rf_data_source = 1'b0;
    o_ld_rf_add      = 1'b0;
    o_rf_add_source  = RF_ADD_OP_0;
    o_output_source  = 1'b0;
    o_tx_valid       = 1'b0;
    case (state)
      ST_WR_ADDR, ST_RD_ADDR: begin
        o_ld_rf_add     = 1'b1;
        o_rf_add_source = RF_ADD_RX_DATA;
      end
      ST_WR_DATA: begin
        o_ld_rf_data     = 1'b1;
        o_rf_data_source = 1'b1;
      end
      ST_WR_COMMIT, ST_OPA_COMMIT, ST_OPB_COMMIT: o_en_w = 1'b1;
      ST_RD_ISSUE: o_en_r = 1'b1;
      ST_RD_WAIT:  o_output_source = 1'b1;
      ST_OPA, ST_OPB: begin
        o_ld_rf_add      = 1'b1;
        o_rf_add_source  = (state == ST_OPA) ? RF_ADD_OP_0 : RF_ADD_OP_1;
        o_ld_rf_data     = 1'b1;
        o_rf_data_source = 1'b1;
      end
      ST_FUNC: o_ld_alu_func = 1'b1;
      ST_ALU_RUN: begin
        o_alu_clk_en = 1'b1;
        o_alu_en     = 1'b1;
      end
      ST_ALU_WAIT: o_alu_clk_en = 1'b1;
      ST_TX_LOAD:  o_output_source = tx_src;
      ST_TX_SEND: begin
        o_tx_valid      = 1'b1;
        o_output_source = tx_src;
      end
      default: ;
    endcase
  end

  assign o_busy      = (state != ST_IDLE);
  // Only an actual abort pulses; a byte or status arriving on the last cycle wins.
  assign o_frame_err = timed_out && (state_next == ST_IDLE);

endmodule

// File: tb/tb_system_ctrl_fsm.sv
// Bench for system_ctrl_fsm: behavioural datapath around the sequencer plus a
// frame-level model predicting RF contents, TX bytes and frame errors.
module tb_system_ctrl_fsm;
  import system_ctrl_fsm_pkg::*;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 255;
  localparam int TO_W    = 8;
  localparam logic [7:0] F_ADD = 8'd0;
  localparam logic [7:0] F_SUB = 8'd1;
  localparam logic [7:0] F_AND = 8'd2;
  localparam logic [7:0] F_OR  = 8'd3;
  localparam logic [7:0] F_XOR = 8'd4;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_valid, reg_file_valid, alu_valid, tx_ready;
  logic       alu_en, ld_alu_func, alu_clk_en, en_r, en_w, ld_rf_data, rf_data_source;
  logic       ld_rf_add, output_source, tx_valid, busy, frame_err;
  logic [1:0] rf_add_source;

  system_ctrl_fsm #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_data_valid(rx_valid),
    .i_reg_file_valid(reg_file_valid), .i_alu_valid(alu_valid), .i_tx_ready(tx_ready),
    .o_alu_en(alu_en), .o_ld_alu_func(ld_alu_func), .o_alu_clk_en(alu_clk_en),
    .o_en_r(en_r), .o_en_w(en_w), .o_ld_rf_data(ld_rf_data),
    .o_rf_data_source(rf_data_source), .o_ld_rf_add(ld_rf_add),
    .o_rf_add_source(rf_add_source), .o_output_source(output_source),
    .o_tx_valid(tx_valid), .o_busy(busy), .o_frame_err(frame_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] f);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [14:0] out_vec();
    return {alu_en, ld_alu_func, alu_clk_en, en_r, en_w, ld_rf_data, rf_data_source,
            ld_rf_add, rf_add_source, output_source, tx_valid, busy, frame_err};
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [7:0] dp_rf [256];
  logic [7:0] dp_addr, dp_data, dp_func, dp_rd, dp_alu, dp_tx;
  int         rd_cnt, alu_cnt;
  int         fixed_lat = 0;

  function automatic int pick_lat();
    return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
  endfunction

  initial begin : dp_env
    logic [7:0] n_addr, n_data, n_func, n_rd, n_alu, n_tx, wr_a, wr_d;
    logic       do_wr;
    int         n_rdc, n_aluc;
    for (int i = 0; i < 256; i++) dp_rf[i] = 8'h00;
    {dp_addr, dp_data, dp_func, dp_rd, dp_alu, dp_tx} = '0;
    rd_cnt = 0; alu_cnt = 0;
    reg_file_valid = 1'b0; alu_valid = 1'b0;
    forever begin
      @(negedge clk);
      n_addr = dp_addr; n_data = dp_data; n_func = dp_func;
      n_rd = dp_rd; n_alu = dp_alu; n_tx = dp_tx;
      n_rdc  = (rd_cnt > 0) ? rd_cnt - 1 : 0;
      n_aluc = (alu_cnt > 0) ? alu_cnt - 1 : 0;
      do_wr = 1'b0; wr_a = dp_addr; wr_d = dp_data;
      if (rst) begin
        n_rdc = 0; n_aluc = 0;
      end else begin
        if (ld_rf_add && rx_valid)
          n_addr = (rf_add_source == RF_ADD_RX_DATA) ? rx_data : {6'd0, rf_add_source};
        if (ld_rf_data && rx_valid) n_data = rf_data_source ? rx_data : dp_alu;
        if (ld_alu_func && rx_valid) n_func = rx_data;
        do_wr = en_w;
        if (en_r) begin
          n_rd  = dp_rf[dp_addr];
          n_rdc = pick_lat();
        end
        if (alu_en) begin
          n_alu  = alu_f(dp_rf[0], dp_rf[1], dp_func);
          n_aluc = pick_lat();
        end
        if (!tx_valid) n_tx = output_source ? dp_rd : dp_alu;
      end
      @(posedge clk); #1;
      if (do_wr) dp_rf[wr_a] = wr_d;
      dp_addr = n_addr; dp_data = n_data; dp_func = n_func;
      dp_rd = n_rd; dp_alu = n_alu; dp_tx = n_tx;
      rd_cnt = n_rdc; alu_cnt = n_aluc;
      reg_file_valid = (rd_cnt == 1);
      alu_valid      = (alu_cnt == 1);
    end
  end

  // TX sink: 0 = random ready, 1 = held low, 2 = always ready
  int ready_mode = 2;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = ($urandom_range(0, 3) != 0);
        1:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] ref_rf [256];
  logic [7:0] exp_q[$];
  int exp_ferr = 0, n_ferr = 0, n_tx = 0, exp_tx = 0;
  int cyc = 0, status_cyc = 0;
  logic prev_tx_valid = 1'b0, prev_stall = 1'b0, prev_os = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (reg_file_valid || alu_valid) status_cyc = cyc;
        if (tx_valid && !prev_tx_valid) chk("tx_latency", cyc - status_cyc, 2);
        if (prev_stall) begin
          chk("tx_valid_hold", tx_valid, 1'b1);
          chk("tx_src_hold", output_source, prev_os);
        end
        if (tx_valid && tx_ready) begin
          n_tx++;
          chk("tx_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("tx_data", dp_tx, exp_q.pop_front());
        end
        if (frame_err) n_ferr++;
      end
      prev_tx_valid = tx_valid;
      prev_stall    = tx_valid && !tx_ready && !rst;
      prev_os       = output_source;
    end
  end

  // ---------------- driver tasks ----------------
  int max_gap = 0;

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int budget = 2 * TIMEOUT + 50;
    at_neg();
    while (busy && budget > 0) begin
      at_neg();
      budget--;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
    send_byte(CMD_RF_WR); send_byte(a); send_byte(d);
    ref_rf[a] = d;
    wait_idle("wr");
  endtask

  task automatic frame_rd(input logic [7:0] a);
    exp_q.push_back(ref_rf[a]); exp_tx++;
    send_byte(CMD_RF_RD); send_byte(a);
    wait_idle("rd");
  endtask

  task automatic frame_alu(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f);
    ref_rf[0] = x; ref_rf[1] = y;
    exp_q.push_back(alu_f(x, y, f)); exp_tx++;
    send_byte(CMD_ALU_OP); send_byte(x); send_byte(y); send_byte(f);
    wait_idle("alu");
  endtask

  task automatic frame_nop(input logic [7:0] f);
    exp_q.push_back(alu_f(ref_rf[0], ref_rf[1], f)); exp_tx++;
    send_byte(CMD_ALU_NOP); send_byte(f);
    wait_idle("nop");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int t, base_tx;
    for (int i = 0; i < 256; i++) ref_rf[i] = 8'h00;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    at_neg();
    chk("reset_outputs", 32'(out_vec()), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // write AA 05 3C: en_w exactly one cycle after the data byte
    send_byte(CMD_RF_WR);
    at_neg();
    chk("wr_addr_ld", {ld_rf_add, rf_add_source}, {1'b1, RF_ADD_RX_DATA});
    send_byte(8'h05);
    at_neg();
    chk("wr_data_ld", {ld_rf_data, rf_data_source}, 2'b11);
    send_byte(8'h3C);
    ref_rf[5] = 8'h3C;
    at_neg();
    chk("wr_commit_en_w", en_w, 1'b1);
    chk("wr_no_tx", tx_valid, 1'b0);
    at_neg();
    chk("wr_en_w_one_cycle", en_w, 1'b0);
    chk("wr_back_idle", busy, 1'b0);

    // read BB 05: en_r one cycle after the address byte
    exp_q.push_back(8'h3C); exp_tx++;
    send_byte(CMD_RF_RD);
    send_byte(8'h05);
    at_neg();
    chk("rd_issue_en_r", en_r, 1'b1);
    at_neg();
    chk("rd_en_r_one_cycle", en_r, 1'b0);
    chk("rd_wait_src", output_source, 1'b1);
    wait_idle("rd_directed");

    // ALU with operands, then on existing operands
    send_byte(CMD_ALU_OP);
    at_neg();
    chk("opa_strobes", {ld_rf_add, rf_add_source, ld_rf_data, rf_data_source},
        {1'b1, RF_ADD_OP_0, 2'b11});
    ref_rf[0] = 8'h07; ref_rf[1] = 8'h03;
    exp_q.push_back(8'h0A); exp_tx++;
    send_byte(8'h07);
    @(posedge clk); #1;
    at_neg();
    chk("opb_add_src", rf_add_source, RF_ADD_OP_1);
    send_byte(8'h03); send_byte(F_ADD);
    wait_idle("alu_add");
    frame_nop(F_SUB);
    chk("rf0_operand", dp_rf[0], 8'h07);
    chk("rf1_operand", dp_rf[1], 8'h03);

    // backpressure: 20 cycles of ready low, bytes meanwhile dropped
    ready_mode = 1;
    exp_q.push_back(ref_rf[5]); exp_tx++;
    send_byte(CMD_RF_RD); send_byte(8'h05);
    t = 50;
    at_neg();
    while (!tx_valid && t > 0) begin at_neg(); t--; end
    chk("bp_tx_valid_seen", tx_valid, 1'b1);
    send_byte(CMD_RF_WR); send_byte(8'h33);
    repeat (16) at_neg();
    chk("bp_valid_stable", tx_valid, 1'b1);
    chk("bp_src_stable", output_source, 1'b1);
    base_tx = n_tx;
    ready_mode = 2;
    at_neg(); at_neg();
    chk("bp_one_transfer", n_tx - base_tx, 1);
    chk("bp_back_idle", busy, 1'b0);

    // timeout: AA 05 then silence
    send_byte(CMD_RF_WR); send_byte(8'h05);
    at_neg();
    repeat (TIMEOUT - 1) at_neg();
    chk("to_no_err_early", frame_err, 1'b0);
    chk("to_still_busy", busy, 1'b1);
    at_neg();
    chk("to_err_at_limit", frame_err, 1'b1);
    chk("to_no_en_w", en_w, 1'b0);
    exp_ferr++;
    at_neg();
    chk("to_idle_after", busy, 1'b0);
    chk("to_err_one_cycle", frame_err, 1'b0);

    // status on the last cycle wins; one cycle later it is an abort
    fixed_lat = TIMEOUT + 1;
    frame_rd(8'h05);
    fixed_lat = TIMEOUT + 2;
    send_byte(CMD_RF_RD); send_byte(8'h05);
    exp_ferr++;
    wait_idle("rd_late");
    repeat (3) at_neg();
    chk("late_valid_ignored", busy, 1'b0);
    fixed_lat = 0;

    // illegal byte in IDLE
    send_byte(8'h55);
    at_neg();
    chk("illegal_not_busy", busy, 1'b0);
    at_neg();
    chk("illegal_still_idle", busy, 1'b0);

    // reset during OPB
    send_byte(CMD_ALU_OP); send_byte(8'h07);
    ref_rf[0] = 8'h07;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    at_neg();
    chk("rst_mid_outputs", 32'(out_vec()), 0);
    frame_wr(8'h09, 8'h5A);
    frame_rd(8'h09);

    // randomized frames
    ready_mode = 0;
    max_gap = 3;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: frame_wr(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        1: frame_rd(8'($urandom_range(0, 15)));
        2: frame_alu(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 5)));
        3: frame_nop(8'($urandom_range(0, 5)));
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == CMD_RF_WR || b == CMD_RF_RD || b == CMD_ALU_OP || b == CMD_ALU_NOP)
            b = 8'h55;
          send_byte(b);
          at_neg();
          chk("rand_illegal_idle", busy, 1'b0);
        end
      endcase
    end
    ready_mode = 2;
    max_gap = 0;
    repeat (5) at_neg();

    // final report
    chk("tx_count", n_tx, exp_tx);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("frame_err_count", n_ferr, exp_ferr);
    for (int i = 0; i < 16; i++) chk($sformatf("rf_%0d", i), dp_rf[i], ref_rf[i]);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
